// File: rtl/reg_arb_pkg.sv
// Shared definitions for the register write arbiter.
//   arb_state_t : arbiter FSM states (IDLE, GRANT)
//   idx_w(n)    : index width for n requesters, never less than 1 bit
package reg_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    function automatic int idx_w(input int n);
        return ($clog2(n) > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational rotate-priority picker.
// Finds the first asserted request searching ptr, ptr+1, ... wrapping at NREQ.
// Ports:
//   req  in  NREQ  request vector
//   ptr  in  IW    index with highest priority (must be < NREQ)
//   any  out 1     at least one request asserted
//   idx  out IW    index of the winning request (0 when any==0)
module rr_picker
    import reg_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IW   = idx_w(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic            any,
    output logic [IW-1:0]   idx
);

    // Walk from the farthest candidate back to ptr so the closest hit is
    // the last assignment. The wrap is an explicit compare-and-subtract so
    // non-power-of-2 NREQ never yields an index >= NREQ.
    always_comb begin
        logic [IW:0] cand;
        any  = 1'b0;
        idx  = '0;
        cand = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            cand = {1'b0, ptr} + (IW+1)'(k);
            if (cand >= (IW+1)'(NREQ)) begin
                cand = cand - (IW+1)'(NREQ);
            end
            if (req[cand[IW-1:0]]) begin
                any = 1'b1;
                idx = cand[IW-1:0];
            end
        end
    end

endmodule

// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter sharing one WIDTH-bit register among NREQ writers.
// Handshake: a requester holds req_valid with its data; the write completes
// in the cycle where req_valid and req_ready are both high. req_ready is a
// registered one-hot grant, so request-to-write latency is a fixed 2 cycles.
// A granted requester that drops valid aborts its slot; the pointer still
// advances past it.
// Ports:
//   clk, reset (synchronous, active-low)
//   req_valid  in  NREQ        per-requester write request
//   req_data   in  NREQ*WIDTH  requester i data in [i*WIDTH +: WIDTH]
//   req_ready  out NREQ        registered one-hot grant
//   q          out WIDTH       shared register
//   q_valid    out 1           pulse the cycle after q is written
//   q_src      out clog2(NREQ) index of last writer
//   busy       out 1           FSM is in GRANT
// Optional feature (macro REG_WRITE_ARBITER_PARITY_EN):
//   q_par   out 1  parity of q, registered with q
//   par_err out 1  high whenever ^q disagrees with q_par
module reg_write_arbiter
    import reg_arb_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ*WIDTH-1:0]    req_data,
    output logic [NREQ-1:0]          req_ready,
    output logic [WIDTH-1:0]         q,
    output logic                     q_valid,
    output logic [$clog2(NREQ)-1:0]  q_src,
`ifdef REG_WRITE_ARBITER_PARITY_EN
    output logic                     q_par,
    output logic                     par_err,
`endif
    output logic                     busy
);

    localparam int IW = idx_w(NREQ);

    arb_state_t       state_q, state_d;
    logic [NREQ-1:0]  gnt_q, gnt_d;
    logic [IW-1:0]    gidx_q, gidx_d;
    logic [IW-1:0]    rr_ptr_q, rr_ptr_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [IW-1:0]    q_src_q, q_src_d;
    logic             q_valid_q, q_valid_d;

    logic             pick_any;
    logic [IW-1:0]    pick_idx;
    logic             sel_valid;
    logic [WIDTH-1:0] sel_data;
    logic [IW-1:0]    ptr_after_g;

    rr_picker #(.NREQ(NREQ), .IW(IW)) u_picker (
        .req (req_valid),
        .ptr (rr_ptr_q),
        .any (pick_any),
        .idx (pick_idx)
    );

    // Data and valid of the granted requester, muxed by the one-hot grant.
    always_comb begin
        sel_data  = '0;
        sel_valid = |(req_valid & gnt_q);
        for (int i = 0; i < NREQ; i++) begin
            if (gnt_q[i]) begin
                sel_data = req_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // Pointer moves one past the granted index, wrapping NREQ-1 -> 0.
    always_comb begin
        logic [IW:0] inc;
        inc = {1'b0, gidx_q} + (IW+1)'(1);
        if (inc >= (IW+1)'(NREQ)) begin
            inc = '0;
        end
        ptr_after_g = inc[IW-1:0];
    end

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        gidx_d    = gidx_q;
        rr_ptr_d  = rr_ptr_q;
        q_d       = q_q;
        q_src_d   = q_src_q;
        q_valid_d = 1'b0;
        case (state_q)
            IDLE: begin
                gnt_d = '0;
                if (pick_any) begin
                    gidx_d = pick_idx;
                    for (int i = 0; i < NREQ; i++) begin
                        gnt_d[i] = (pick_idx == IW'(i));
                    end
                    state_d = GRANT;
                end
            end
            GRANT: begin
                // Write on completed handshake; abort if the requester withdrew.
                gnt_d    = '0;
                rr_ptr_d = ptr_after_g;
                state_d  = IDLE;
                if (sel_valid) begin
                    q_d       = sel_data;
                    q_src_d   = gidx_q;
                    q_valid_d = 1'b1;
                end
            end
            default: begin
                gnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= IDLE;
            gnt_q     <= '0;
            gidx_q    <= '0;
            rr_ptr_q  <= '0;
            q_q       <= '0;
            q_src_q   <= '0;
            q_valid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            gidx_q    <= gidx_d;
            rr_ptr_q  <= rr_ptr_d;
            q_q       <= q_d;
            q_src_q   <= q_src_d;
            q_valid_q <= q_valid_d;
        end
    end

    assign req_ready = gnt_q;
    assign q         = q_q;
    assign q_valid   = q_valid_q;
    assign q_src     = q_src_q;
    assign busy      = (state_q == GRANT);

`ifdef REG_WRITE_ARBITER_PARITY_EN
    logic q_par_q, q_par_d;

    assign q_par_d = ^q_d;

    always_ff @(posedge clk) begin
        if (!reset) begin
            q_par_q <= 1'b0;
        end else begin
            q_par_q <= q_par_d;
        end
    end

    assign q_par   = q_par_q;
    assign par_err = (^q_q) != q_par_q;
`endif

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Bench for reg_write_arbiter: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a behavioural model.
module tb_reg_write_arbiter;

    localparam int NREQ  = 4;
    localparam int WIDTH = 8;
    localparam int SW    = 2;
    localparam int W     = SW + WIDTH;

    // ---------------- clock / reset ----------------
    logic                  clk = 1'b0;
    logic                  reset;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ*WIDTH-1:0] req_data;
    logic [NREQ-1:0]       req_ready;
    logic [WIDTH-1:0]      q;
    logic                  q_valid;
    logic [SW-1:0]         q_src;
    logic                  busy;
`ifdef REG_WRITE_ARBITER_PARITY_EN
    logic                  q_par;
    logic                  par_err;
`endif

    always #5 clk = ~clk;

    reg_write_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .q         (q),
        .q_valid   (q_valid),
        .q_src     (q_src),
`ifdef REG_WRITE_ARBITER_PARITY_EN
        .q_par     (q_par),
        .par_err   (par_err),
`endif
        .busy      (busy)
    );

    int n_checks = 0;
    int n_bad    = 0;
    bit chk_en   = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Arbiter described by its rules: a pending grant index (or none),
    // a priority pointer, and the register contents.
    bit               m_busy;
    int               m_g;
    int               m_ptr;
    logic [WIDTH-1:0] m_q;
    int               m_src;
    bit               m_qv;
    logic [W-1:0]     exp_q[$];

    always @(posedge clk) begin
        if (!reset) begin
            m_busy = 0; m_g = 0; m_ptr = 0; m_q = '0; m_src = 0; m_qv = 0;
            exp_q.delete();
        end else if (!m_busy) begin
            m_qv = 0;
            for (int k = 0; k < NREQ; k++) begin
                int i;
                i = (m_ptr + k) % NREQ;
                if (!m_busy && req_valid[i]) begin
                    m_busy = 1;
                    m_g    = i;
                end
            end
        end else begin
            if (req_valid[m_g]) begin
                m_q   = req_data[m_g*WIDTH +: WIDTH];
                m_src = m_g;
                m_qv  = 1;
                exp_q.push_back({SW'(m_g), m_q});
            end else begin
                m_qv = 0;
            end
            m_ptr  = (m_g + 1) % NREQ;
            m_busy = 0;
        end
    end

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            chk("ready", 32'(req_ready), m_busy ? (32'd1 << m_g) : 32'd0);
            chk("busy", 32'(busy), 32'(m_busy));
            chk("q", 32'(q), 32'(m_q));
            chk("q_valid", 32'(q_valid), 32'(m_qv));
            if (m_qv) chk("q_src", 32'(q_src), 32'(m_src));
`ifdef REG_WRITE_ARBITER_PARITY_EN
            chk("q_par", 32'(q_par), 32'(^m_q));
            chk("par_err", 32'(par_err), 32'd0);
`endif
            if (q_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("sb_unexpected_write", 32'({q_src, q}), 32'hFFFF_FFFF);
                end else begin
                    logic [W-1:0] e;
                    e = exp_q.pop_front();
                    chk("sb_write", 32'({q_src, q}), 32'(e));
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_data(input int i, input logic [WIDTH-1:0] v);
        req_data[i*WIDTH +: WIDTH] = v;
    endtask

    // ---------------- stimulus ----------------
    int               wr_cyc[$];
    int               wr_src[$];
    logic [WIDTH-1:0] wr_dat[$];

    initial begin
        reset     = 1'b0;
        req_valid = '1;
        req_data  = '0;

        // Reset held 2 cycles with every requester asking.
        for (int c = 0; c < 2; c++) begin
            tick();
            chk_en = 1'b1;
            chk("rst_q", 32'(q), 32'd0);
            chk("rst_qv", 32'(q_valid), 32'd0);
            chk("rst_ready", 32'(req_ready), 32'd0);
            chk("rst_busy", 32'(busy), 32'd0);
        end

        // Single request from requester 2.
        reset     = 1'b1;
        req_valid = 4'b0100;
        set_data(2, 8'hA5);
        tick();
        chk("single_ready", 32'(req_ready), 32'h4);
        chk("single_busy", 32'(busy), 32'd1);
        tick();
        chk("single_q", 32'(q), 32'hA5);
        chk("single_src", 32'(q_src), 32'd2);
        chk("single_qv", 32'(q_valid), 32'd1);
        req_valid = '0;
        tick();
        chk("single_qv_low", 32'(q_valid), 32'd0);
        chk("single_q_hold", 32'(q), 32'hA5);

        // All four held after a fresh reset: src 0,1,2,3,0 every 2 cycles.
        reset = 1'b0;
        tick();
        reset     = 1'b1;
        req_valid = '1;
        for (int i = 0; i < NREQ; i++) set_data(i, WIDTH'(i + 1));
        for (int c = 1; c <= 10; c++) begin
            tick();
            if (q_valid === 1'b1) begin
                wr_cyc.push_back(c);
                wr_src.push_back(int'(q_src));
                wr_dat.push_back(q);
            end
        end
        chk("rr_count", 32'(wr_cyc.size()), 32'd5);
        for (int k = 0; k < wr_cyc.size() && k < 5; k++) begin
            chk("rr_cycle", 32'(wr_cyc[k]), 32'(2 * (k + 1)));
            chk("rr_src", 32'(wr_src[k]), 32'(k % 4));
            chk("rr_data", 32'(wr_dat[k]), 32'((k % 4) + 1));
        end

        // Withdrawal: grant goes to 1, it drops, next grant to 2.
        req_valid = 4'b0110;
        set_data(1, 8'h55);
        set_data(2, 8'h66);
        tick();
        chk("wd_ready1", 32'(req_ready), 32'h2);
        req_valid = 4'b0100;
        tick();
        chk("wd_no_write", 32'(q_valid), 32'd0);
        chk("wd_q_hold", 32'(q), 32'h01);
        chk("wd_idle", 32'(busy), 32'd0);
        tick();
        chk("wd_ready2", 32'(req_ready), 32'h4);
        tick();
        chk("wd_q2", 32'(q), 32'h66);
        chk("wd_src2", 32'(q_src), 32'd2);

        // Reset while busy.
        req_valid = '1;
        tick();
        chk("rb_busy", 32'(busy), 32'd1);
        chk("rb_ready3", 32'(req_ready), 32'h8);
        reset = 1'b0;
        tick();
        chk("rb_idle", 32'(busy), 32'd0);
        chk("rb_gnt", 32'(req_ready), 32'd0);
        chk("rb_q", 32'(q), 32'd0);
        chk("rb_src", 32'(q_src), 32'd0);
        reset     = 1'b1;
        req_valid = 4'b1010;
        tick();
        chk("rb_lowest", 32'(req_ready), 32'h2);

        // Randomized traffic checked by the model every cycle.
        for (int c = 0; c < 1500; c++) begin
            reset = ($urandom_range(0, 63) != 0);
            if ($urandom_range(0, 1) == 0) req_valid = NREQ'($urandom_range(0, 15));
            for (int i = 0; i < NREQ; i++) set_data(i, WIDTH'($urandom_range(0, 255)));
            tick();
        end
        req_valid = '0;
        tick();
        tick();
        tick();
        chk("sb_empty", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
